// File: rtl/wash_panel.sv
// -----------------------------------------------------------------------------
// wash_panel
//
// Front-panel controller for the wash timer. It sits directly upstream of the
// countdown/display stage and:
//   - synchronises and debounces three raw push-buttons (start, mode, stop),
//   - turns each debounced rising edge into a single-cycle press event,
//   - keeps the selected wash program and its BCD preset time,
//   - runs the IDLE / RUN / PAUSE / DONE control FSM that drives the
//     countdown stage (run enable and load strobe).
//
// Parameters
//   DEB_CYCLES  : consecutive stable synchronised cycles needed before a new
//                 button level is accepted (>= 2).
//   BUZZ_CYCLES : length of the DONE buzzer dwell in cycles (>= 1).
//
// Build option
//   PANEL_BUZZER_EN : when defined, DONE holds the buzzer on for up to
//                     BUZZ_CYCLES cycles and leaves on timeout or any press.
//                     When undefined there is no buzz counter, the buzzer is
//                     tied low and DONE lasts exactly one cycle.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   btn_start    in   raw start/pause button (asynchronous)
//   btn_mode     in   raw program-select button (asynchronous)
//   btn_stop     in   raw stop button (asynchronous)
//   done_in      in   countdown reached 00 (level)
//   on           out  run enable to the countdown stage (high only in RUN)
//   load         out  one-cycle strobe, countdown loads the preset
//   mode         out  selected program 0..2
//   preset_tens  out  BCD tens digit of the preset seconds
//   preset_ones  out  BCD ones digit of the preset seconds
//   state        out  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   buzzer       out  end-of-wash indicator
//
// Handshake note: there is no valid/ready channel here. The only strobe is
// `load`, a one-cycle pulse issued on the IDLE->RUN transition; the countdown
// stage must sample it every cycle. `done_in` is a level, sampled every cycle.
// -----------------------------------------------------------------------------
module wash_panel #(
  parameter int unsigned DEB_CYCLES  = 2000000,
  parameter int unsigned BUZZ_CYCLES = 300000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_stop,
  input  logic       done_in,
  output logic       on,
  output logic       load,
  output logic [1:0] mode,
  output logic [3:0] preset_tens,
  output logic [3:0] preset_ones,
  output logic [1:0] state,
  output logic       buzzer
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // ---------------------------------------------------------------------------
  generate
    if (DEB_CYCLES < 2) begin : g_bad_deb
      $error("wash_panel: DEB_CYCLES must be >= 2");
    end
    if (BUZZ_CYCLES < 1) begin : g_bad_buzz
      $error("wash_panel: BUZZ_CYCLES must be >= 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Button index map used by all per-button vectors below
  // ---------------------------------------------------------------------------
  localparam int B_START = 0;
  localparam int B_MODE  = 1;
  localparam int B_STOP  = 2;

  localparam int                DW       = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0]     DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers and debouncers (one lane per button)
  // ---------------------------------------------------------------------------
  logic [2:0]          raw;
  logic [2:0]          sync1_q, sync1_d;
  logic [2:0]          sync2_q, sync2_d;
  logic [2:0]          deb_q, deb_d;
  logic [2:0]          deb_dly_q, deb_dly_d;
  logic [2:0][DW-1:0]  cnt_q, cnt_d;
  logic [2:0]          press;

  assign raw = {btn_stop, btn_mode, btn_start};

  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    deb_dly_d = deb_q;
    deb_d     = deb_q;
    cnt_d     = '0;
    for (int i = 0; i < 3; i++) begin
      // The counter only runs while the synchronised level disagrees with the
      // accepted level; any agreement restarts the stability window.
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = ~deb_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  // Rising edge of the accepted level only; releases generate nothing.
  assign press = deb_q & ~deb_dly_q;

  logic start_p, mode_p, stop_p;
  assign start_p = press[B_START];
  assign mode_p  = press[B_MODE];
  assign stop_p  = press[B_STOP];

  // ---------------------------------------------------------------------------
  // Optional buzz counter
  // ---------------------------------------------------------------------------
`ifdef PANEL_BUZZER_EN
  localparam int            BW        = $clog2(BUZZ_CYCLES + 1);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);

  logic [BW-1:0] buzz_q, buzz_d;
  logic          any_p;
  logic          buzz_end;

  assign any_p    = |press;
  assign buzz_end = (buzz_q == BUZZ_LAST);
`endif

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic       on_q, on_d;
  logic       load_q, load_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      on_q    <= 1'b0;
      load_q  <= 1'b0;
`ifdef PANEL_BUZZER_EN
      buzz_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      on_q    <= on_d;
      load_q  <= load_d;
`ifdef PANEL_BUZZER_EN
      buzz_q  <= buzz_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next-state logic
  // Priority inside a cycle is stop > done_in > start > mode.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        // A stop press in IDLE has nothing to stop but still outranks the
        // lower-priority presses landing in the same cycle. A lingering
        // done_in level is irrelevant here.
        if (stop_p) begin
          state_d = S_IDLE;
        end else if (start_p) begin
          state_d = S_RUN;
        end else if (mode_p) begin
          mode_d = (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
        end
      end
      S_RUN: begin
        if (stop_p) begin
          state_d = S_IDLE;
        end else if (done_in) begin
          state_d = S_DONE;
        end else if (start_p) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        // The countdown is frozen in PAUSE, so done_in is not meaningful.
        if (stop_p) begin
          state_d = S_IDLE;
        end else if (start_p) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
`ifdef PANEL_BUZZER_EN
        if (any_p || buzz_end) begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM: output logic
  // on and load are registered versions of decisions taken on state_d, so
  // they change on the same edge as the state itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    on_d        = (state_d == S_RUN);
    load_d      = (state_q == S_IDLE) && (state_d == S_RUN);
    preset_tens = 4'd3;
    preset_ones = 4'd0;
    case (mode_q)
      2'd0:    begin preset_tens = 4'd3; preset_ones = 4'd0; end
      2'd1:    begin preset_tens = 4'd6; preset_ones = 4'd0; end
      2'd2:    begin preset_tens = 4'd9; preset_ones = 4'd9; end
      default: begin preset_tens = 4'd3; preset_ones = 4'd0; end
    endcase
`ifdef PANEL_BUZZER_EN
    // Counter restarts whenever DONE is not occupied, so every DONE visit
    // begins at zero.
    buzz_d = (state_q == S_DONE) ? buzz_q + BW'(1) : '0;
    buzzer = (state_q == S_DONE);
`else
    buzzer = 1'b0;
`endif
  end

  assign on    = on_q;
  assign load  = load_q;
  assign mode  = mode_q;
  assign state = state_q;

endmodule
